// File: rtl/controls_pkg.sv
// Shared types and helpers for the player-controller input stage:
// command encoding, button bit positions, FSM state encoding.
package controls_pkg;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_FWD,
    CMD_BACK,
    CMD_LEFT,
    CMD_RIGHT
  } cmd_t;

  localparam int BTN_FWD   = 3;
  localparam int BTN_BACK  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE   = 2'd0;
  localparam fsm_state_t ST_ARMED  = 2'd1;
  localparam fsm_state_t ST_HOLD   = 2'd2;
  localparam fsm_state_t ST_REPEAT = 2'd3;

  // Opposing pairs cancel each other before priority is applied.
  function automatic cmd_t select_cmd(input logic [3:0] held);
    logic move_ok;
    logic rot_ok;
    cmd_t result;
    move_ok = !(held[BTN_FWD] && held[BTN_BACK]);
    rot_ok  = !(held[BTN_LEFT] && held[BTN_RIGHT]);
    result  = CMD_NONE;
    if (move_ok && held[BTN_FWD]) begin
      result = CMD_FWD;
    end else if (move_ok && held[BTN_BACK]) begin
      result = CMD_BACK;
    end else if (rot_ok && held[BTN_LEFT]) begin
      result = CMD_LEFT;
    end else if (rot_ok && held[BTN_RIGHT]) begin
      result = CMD_RIGHT;
    end
    return result;
  endfunction

  // Bit order {fwd, back, left, right}.
  function automatic logic [3:0] cmd_onehot(input cmd_t cmd);
    logic [3:0] bits;
    case (cmd)
      CMD_FWD:   bits = 4'b1000;
      CMD_BACK:  bits = 4'b0100;
      CMD_LEFT:  bits = 4'b0010;
      CMD_RIGHT: bits = 4'b0001;
      default:   bits = 4'b0000;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchronizer followed by a stability timer that
// only accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce
  import controls_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 371250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  // Down-counter reloads whenever the input agrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= CNT_LOAD;
      level <= 1'b0;
    end else if (sync_q == level) begin
      cnt <= CNT_LOAD;
    end else if (cnt == '0) begin
      cnt   <= CNT_LOAD;
      level <= sync_q;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/move_cmd_gen.sv
// Turns four raw buttons into one-hot movement commands, issued only on
// frame ticks while the raycaster is idle, with hold-to-repeat.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no command selected, nothing pending
// ST_ARMED  | command loaded and pending, waiting for an eligible tick
// ST_HOLD   | first issue done, counting ticks to the first auto-repeat
// ST_REPEAT | auto-repeating every REPEAT_FRAMES ticks
module move_cmd_gen
  import controls_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 371250,
  parameter int HOLD_FRAMES     = 15,
  parameter int REPEAT_FRAMES   = 4
) (
  input  logic       pixel_clk_in,
  input  logic       rst_n_in,
  input  logic [3:0] btn_in,
  input  logic       frame_tick_in,
  input  logic       busy_in,
  output logic       moveFwd,
  output logic       moveBack,
  output logic       rotLeft,
  output logic       rotRight,
  output logic       valid_out
);

  localparam int FRAME_MAX = (HOLD_FRAMES > REPEAT_FRAMES) ? HOLD_FRAMES : REPEAT_FRAMES;
  localparam int CNT_W     = $clog2(FRAME_MAX + 1);

  logic [3:0]       btn_db;
  cmd_t             sel;
  cmd_t             cur_cmd;
  cmd_t             cur_cmd_nxt;
  fsm_state_t       state;
  fsm_state_t       state_nxt;
  logic             pending;
  logic             pending_nxt;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] frame_cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_limit;
  logic             issue;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (pixel_clk_in),
      .rst_n(rst_n_in),
      .raw  (btn_in[i]),
      .level(btn_db[i])
    );
  end

  assign sel   = select_cmd(btn_db);
  assign issue = frame_tick_in && pending && !busy_in;

  assign cnt_inc  = (frame_cnt == '1) ? frame_cnt : frame_cnt + 1'b1;
  assign at_limit = (32'(cnt_inc) >= ((state == ST_HOLD) ? HOLD_FRAMES : REPEAT_FRAMES));

  always_comb begin
    state_nxt     = state;
    cur_cmd_nxt   = cur_cmd;
    pending_nxt   = pending;
    frame_cnt_nxt = frame_cnt;
    case (state)
      ST_IDLE: begin
        if (sel != CMD_NONE) begin
          cur_cmd_nxt = sel;
          pending_nxt = 1'b1;
          state_nxt   = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // A released button keeps its pending issue so a short tap still fires.
        if ((sel != CMD_NONE) && (sel != cur_cmd)) begin
          cur_cmd_nxt = sel;
          pending_nxt = 1'b1;
        end else if (issue) begin
          pending_nxt   = 1'b0;
          frame_cnt_nxt = CNT_W'(1);
          state_nxt     = (sel == CMD_NONE) ? ST_IDLE : ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (sel == CMD_NONE) begin
          pending_nxt = 1'b0;
          state_nxt   = ST_IDLE;
        end else if (sel != cur_cmd) begin
          cur_cmd_nxt = sel;
          pending_nxt = 1'b1;
          state_nxt   = ST_ARMED;
        end else begin
          if (issue) begin
            pending_nxt = 1'b0;
          end
          if (frame_tick_in) begin
            // A due tick that also issues would only queue a second strobe.
            if (at_limit) begin
              if (!issue) begin
                pending_nxt = 1'b1;
              end
              frame_cnt_nxt = '0;
              state_nxt     = ST_REPEAT;
            end else begin
              frame_cnt_nxt = cnt_inc;
            end
          end
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        pending_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= ST_IDLE;
      cur_cmd   <= CMD_NONE;
      pending   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cur_cmd   <= cur_cmd_nxt;
      pending   <= pending_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out <= 1'b0;
      moveFwd   <= 1'b0;
      moveBack  <= 1'b0;
      rotLeft   <= 1'b0;
      rotRight  <= 1'b0;
    end else begin
      valid_out <= issue;
      if (issue) begin
        {moveFwd, moveBack, rotLeft, rotRight} <= cmd_onehot(cur_cmd);
      end
    end
  end

endmodule

// File: tb/tb_move_cmd_gen.sv
// Bench for move_cmd_gen: directed tables and sequences, then random
// stimulus against a behavioural model of the command rules.
module tb_move_cmd_gen;

  localparam int DEB  = 8;
  localparam int HOLD = 3;
  localparam int REP  = 2;

  logic       pixel_clk_in = 1'b0;
  logic       rst_n_in     = 1'b0;
  logic [3:0] btn_in       = 4'b0000;
  logic       frame_tick_in = 1'b0;
  logic       busy_in      = 1'b0;
  logic       moveFwd, moveBack, rotLeft, rotRight, valid_out;

  move_cmd_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_FRAMES    (HOLD),
    .REPEAT_FRAMES  (REP)
  ) dut (
    .pixel_clk_in (pixel_clk_in),
    .rst_n_in     (rst_n_in),
    .btn_in       (btn_in),
    .frame_tick_in(frame_tick_in),
    .busy_in      (busy_in),
    .moveFwd      (moveFwd),
    .moveBack     (moveBack),
    .rotLeft      (rotLeft),
    .rotRight     (rotRight),
    .valid_out    (valid_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  int tick_period = 50;
  int strobe_cyc[$];
  logic [3:0] strobe_bits[$];
  bit model_on = 1'b0;

  // behavioural model state
  logic [3:0] m_s1 = '0, m_s2 = '0, m_db = '0;
  int m_run[4] = '{0, 0, 0, 0};
  int m_cmd = 0, m_ticks = 0, m_period = HOLD;
  bit m_pend = 0, m_active = 0, m_waiting = 0, m_valid = 0;
  logic [3:0] m_bits = '0;

  task automatic check_eq(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc_n);
    end
  endtask

  // 0 none, 1 fwd, 2 back, 3 left, 4 right
  function automatic int sel_of(input logic [3:0] b);
    bit f, bk, l, r;
    f  = b[3] && !b[2];
    bk = b[2] && !b[3];
    l  = b[1] && !b[0];
    r  = b[0] && !b[1];
    if (f) return 1;
    if (bk) return 2;
    if (l) return 3;
    if (r) return 4;
    return 0;
  endfunction

  function automatic logic [3:0] bits_of(input int c);
    case (c)
      1: return 4'b1000;
      2: return 4'b0100;
      3: return 4'b0010;
      4: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_edge();
    int sel;
    bit iss;
    if (!rst_n_in) begin
      m_s1 = '0; m_s2 = '0; m_db = '0;
      for (int b = 0; b < 4; b++) m_run[b] = 0;
      m_cmd = 0; m_ticks = 0; m_period = HOLD;
      m_pend = 0; m_active = 0; m_waiting = 0; m_valid = 0; m_bits = '0;
      return;
    end
    sel = sel_of(m_db);
    iss = frame_tick_in && m_pend && !busy_in;
    for (int b = 0; b < 4; b++) begin
      if (m_s2[b] != m_db[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_db[b] = m_s2[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_in;
    m_valid = iss;
    if (iss) m_bits = bits_of(m_cmd);
    if (!m_active) begin
      if (sel != 0) begin
        m_cmd = sel; m_pend = 1; m_active = 1; m_waiting = 1;
      end
    end else if (m_waiting) begin
      if (sel != 0 && sel != m_cmd) begin
        m_cmd = sel; m_pend = 1;
      end else if (iss) begin
        m_pend = 0;
        if (sel == 0) m_active = 0;
        else begin
          m_waiting = 0; m_ticks = 1; m_period = HOLD;
        end
      end
    end else begin
      if (iss) m_pend = 0;
      if (sel == 0) begin
        m_active = 0; m_pend = 0;
      end else if (sel != m_cmd) begin
        m_cmd = sel; m_pend = 1; m_waiting = 1;
      end else if (frame_tick_in) begin
        m_ticks++;
        if (m_ticks >= m_period) begin
          if (!iss) m_pend = 1;
          m_ticks = 0;
          m_period = REP;
        end
      end
    end
  endtask

  task automatic step();
    cyc_n++;
    frame_tick_in = (cyc_n % tick_period == 0);
    @(posedge pixel_clk_in);
    if (model_on) model_edge();
    #1;
    if (valid_out) begin
      strobe_cyc.push_back(cyc_n);
      strobe_bits.push_back({moveFwd, moveBack, rotLeft, rotRight});
    end
    if (model_on)
      check_eq("model", int'({valid_out, moveFwd, moveBack, rotLeft, rotRight}),
               int'({m_valid, m_bits}));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_after_tick();
    do step(); while (cyc_n % tick_period != 0);
  endtask

  task automatic clear_strobes();
    strobe_cyc.delete();
    strobe_bits.delete();
  endtask

  typedef struct packed {
    logic [3:0] btn;
    logic       exp_valid;
    logic [3:0] exp_bits;
  } vec_t;

  vec_t vecs[10];
  int rep_off[4] = '{0, 150, 250, 350};

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, pc, exp_c;
    vecs[0] = '{4'b1000, 1'b1, 4'b1000};
    vecs[1] = '{4'b0100, 1'b1, 4'b0100};
    vecs[2] = '{4'b0010, 1'b1, 4'b0010};
    vecs[3] = '{4'b0001, 1'b1, 4'b0001};
    vecs[4] = '{4'b1101, 1'b1, 4'b0001};
    vecs[5] = '{4'b1010, 1'b1, 4'b1000};
    vecs[6] = '{4'b1100, 1'b0, 4'b0000};
    vecs[7] = '{4'b0011, 1'b0, 4'b0000};
    vecs[8] = '{4'b1111, 1'b0, 4'b0000};
    vecs[9] = '{4'b0111, 1'b1, 4'b0100};

    run(3);
    check_eq("reset outputs", int'({valid_out, moveFwd, moveBack, rotLeft, rotRight}), 0);
    rst_n_in = 1'b1;
    run(5);

    // held fwd: first issue, then repeats at +3, +5, +7 ticks
    wait_after_tick();
    clear_strobes();
    btn_in = 4'b1000;
    pc = cyc_n + 1;
    exp_c = ((pc + 11 + tick_period - 1) / tick_period) * tick_period;
    for (int i = 0; i < 600 && strobe_cyc.size() < 4; i++) step();
    check_eq("hold strobe count", strobe_cyc.size(), 4);
    for (int i = 0; i < 4 && i < strobe_cyc.size(); i++) begin
      check_eq("hold strobe cycle", strobe_cyc[i], exp_c + rep_off[i]);
      check_eq("hold strobe bits", int'(strobe_bits[i]), 8);
    end
    btn_in = 4'b0000;
    run(400);
    check_eq("no strobe after release", strobe_cyc.size(), 4);

    // glitch shorter than the debounce window
    wait_after_tick();
    clear_strobes();
    btn_in = 4'b1000;
    run(5);
    btn_in = 4'b0000;
    run(200);
    check_eq("glitch strobes", strobe_cyc.size(), 0);

    // short tap issues exactly once
    wait_after_tick();
    t = cyc_n;
    clear_strobes();
    btn_in = 4'b0010;
    run(20);
    btn_in = 4'b0000;
    run(150);
    check_eq("tap strobe count", strobe_cyc.size(), 1);
    if (strobe_cyc.size() > 0) begin
      check_eq("tap strobe cycle", strobe_cyc[0], t + 50);
      check_eq("tap strobe bits", int'(strobe_bits[0]), 2);
    end

    // selection table
    for (int v = 0; v < 10; v++) begin
      wait_after_tick();
      t = cyc_n;
      clear_strobes();
      btn_in = vecs[v].btn;
      run(50);
      btn_in = 4'b0000;
      run(120);
      check_eq($sformatf("table[%0d] count", v), strobe_cyc.size(), vecs[v].exp_valid ? 1 : 0);
      if (vecs[v].exp_valid && strobe_cyc.size() > 0) begin
        check_eq($sformatf("table[%0d] cycle", v), strobe_cyc[0], t + 50);
        check_eq($sformatf("table[%0d] bits", v), int'(strobe_bits[0]), int'(vecs[v].exp_bits));
      end
    end

    // busy blocks two ticks, issue on the first free one
    wait_after_tick();
    t = cyc_n;
    clear_strobes();
    busy_in = 1'b1;
    btn_in = 4'b1000;
    run(20);
    btn_in = 4'b0000;
    run(80);
    busy_in = 1'b0;
    run(100);
    check_eq("busy strobe count", strobe_cyc.size(), 1);
    if (strobe_cyc.size() > 0) check_eq("busy strobe cycle", strobe_cyc[0], t + 150);

    // async reset in REPEAT, then full re-debounce
    wait_after_tick();
    t = cyc_n;
    clear_strobes();
    btn_in = 4'b1000;
    run(220);
    check_eq("pre-reset strobes", strobe_cyc.size(), 2);
    check_eq("pre-reset moveFwd", int'(moveFwd), 1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_eq("async reset outputs", int'({valid_out, moveFwd, moveBack, rotLeft, rotRight}), 0);
    run(25);
    clear_strobes();
    rst_n_in = 1'b1;
    run(80);
    check_eq("post-reset strobe count", strobe_cyc.size(), 1);
    if (strobe_cyc.size() > 0) check_eq("post-reset strobe cycle", strobe_cyc[0], t + 300);
    btn_in = 4'b0000;
    run(100);

    // random stimulus against the model
    tick_period = 16;
    model_on = 1'b1;
    rst_n_in = 1'b0;
    run(3);
    rst_n_in = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) btn_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) busy_in = ~busy_in;
      if (i == 2000) rst_n_in = 1'b0;
      if (i == 2003) rst_n_in = 1'b1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
